int_priority_ctrl: RTL and testbench
====================================

INT_PRIORITY_CTRL -- requirements
Module: int_priority_ctrl

Interface
REQ-001 Parameter NUM_LINES, 8, number of interrupt request lines; fixed at 8, no other value supported.
REQ-002 fast_clock_i  input  1  system clock; all state updates on rising edge.
REQ-003 reset_i  input  1  reset, asynchronous and active-high.
REQ-004 irq_i  input  8  raw interrupt request lines, synchronous to fast_clock_i, active-high.
REQ-005 addr_i  input  2  register select: 0 MASK, 1 PENDING, 2 VBASE, 3 STATUS/EOI.
REQ-006 wr_i  input  1  single-cycle register write strobe.
REQ-007 dat_i  input  8  write data.
REQ-008 dat_o  output  8  read data, combinational from addr_i.
REQ-009 iack_i  input  1  single-cycle CPU interrupt-acknowledge strobe.
REQ-010 n_int_o  output  1  interrupt to CPU, active-low.
REQ-011 vec_o  output  8  interrupt vector, registered, valid from the cycle after the accepted iack_i.

Function
REQ-012 Previous irq_i sample is registered; a 0->1 transition on irq_i[n] SHALL set pending[n] on that edge.
REQ-013 Write to PENDING SHALL clear each pending bit whose dat_i bit is 1 (write-1-to-clear).
REQ-014 Same-cycle set (edge) and clear (write or ack) of one pending bit: set wins, bit stays 1.
REQ-015 MASK: 1 = enabled; read/write; eligible = pending & mask.
REQ-016 VBASE: read/write, 8 bits stored; vector = {VBASE[7:4], idx[2:0], 1'b0}.
REQ-017 STATUS read = {in_service, 4'b0000, idx[2:0]}; STATUS write, any data, = EOI.
REQ-018 Priority: lowest eligible index wins (line 0 highest); pure combinational encode.
REQ-019 FSM states IDLE, REQ, SERV; encoding free.
REQ-020 IDLE: n_int_o=1; if eligible != 0, latch winning idx, go REQ next cycle.
REQ-021 REQ: n_int_o=0; winner re-evaluated each cycle, higher priority arrival replaces idx before ack.
REQ-022 REQ: if eligible becomes 0 (masked/cleared) without iack_i, go IDLE, n_int_o=1 next cycle.
REQ-023 REQ with iack_i=1: clear pending[idx], load vec_o, set in_service=1, go SERV; n_int_o=1 next cycle.
REQ-024 iack_i outside REQ SHALL be ignored; vec_o and state unchanged.
REQ-025 SERV: n_int_o=1, no new request raised; pending bits continue to latch.
REQ-026 SERV with EOI write: in_service=0, go IDLE; next request, if eligible, asserts n_int_o two cycles after EOI.
REQ-027 EOI in IDLE or REQ SHALL have no effect.
REQ-028 Latency: irq_i edge at cycle k (idle, enabled) -> pending at k+1 -> n_int_o low at k+2.

Reset
REQ-029 reset_i asserted SHALL immediately force: state IDLE, pending 0, mask 0x00, VBASE 0x00, in_service 0, idx 0, vec_o 0x00, n_int_o 1, irq history 0.
REQ-030 Reset mid-REQ or mid-SERV SHALL drop n_int_o and discard the in-service line, no EOI needed.
REQ-031 First irq_i edge after reset release is detected only if irq_i was 0 in the first post-reset sample.

Verification
REQ-032 MASK=0xFF, VBASE=0x40, pulse irq_i[3] -> n_int_o low 2 cycles later; iack_i -> vec_o=0x46, PENDING=0x00, STATUS=0x83, n_int_o high.
REQ-033 MASK=0xFF, irq_i[5] then irq_i[1] before ack -> ack yields vec_o idx 1; EOI -> n_int_o re-asserts, ack yields idx 5.
REQ-034 MASK=0x00, pulse irq_i[2] -> PENDING=0x04, n_int_o stays 1; write MASK=0x04 -> n_int_o low 2 cycles later.
REQ-035 In REQ for line 4, write MASK=0x00 -> IDLE, n_int_o high next cycle, PENDING still 0x10.
REQ-036 Edge on irq_i[0] in same cycle as PENDING write 0x01 -> PENDING bit 0 = 1.
REQ-037 Assert reset_i while in SERV -> all outputs at reset values same cycle; STATUS=0x00.

Source files
------------

// File: rtl/int_priority_ctrl.sv
// Eight-line vectored interrupt controller: edge-latched pending bits, mask,
// fixed lowest-index-first priority and an IDLE/REQ/SERV handshake with the CPU.
module int_priority_ctrl #(
  parameter int NUM_LINES = 8
) (
  input  logic                 fast_clock_i,
  input  logic                 reset_i,
  input  logic [NUM_LINES-1:0] irq_i,
  input  logic [1:0]           addr_i,
  input  logic                 wr_i,
  input  logic [7:0]           dat_i,
  output logic [7:0]           dat_o,
  input  logic                 iack_i,
  output logic                 n_int_o,
  output logic [7:0]           vec_o
);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_VBASE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_LINES-1:0] irq_prev_q;
  logic                 hist_valid_q;
  logic [NUM_LINES-1:0] pending_q;
  logic [NUM_LINES-1:0] pending_d;
  logic [NUM_LINES-1:0] mask_q;
  logic [7:0]           vbase_q;
  logic [2:0]           idx_q;
  logic                 in_service_q;
  logic [7:0]           vec_q;
  logic                 n_int_q;

  logic [NUM_LINES-1:0] edge_s;
  logic [NUM_LINES-1:0] clear_s;
  logic [NUM_LINES-1:0] eligible_s;
  logic [2:0]           winner_s;
  logic                 ack_s;
  logic                 eoi_s;

  function automatic logic [2:0] lowest_index(input logic [NUM_LINES-1:0] v);
    lowest_index = 3'd0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_index = i[2:0];
      end else begin
        lowest_index = lowest_index;
      end
    end
  endfunction

  // Edge detect, pending next-state (set beats clear) and priority encode.
  // The first sample after reset only primes the history, so a line held
  // high through reset is not taken as an edge.
  always_comb begin
    edge_s     = hist_valid_q ? (irq_i & ~irq_prev_q) : {NUM_LINES{1'b0}};
    ack_s      = (state_q == ST_REQ) && iack_i;
    eoi_s      = wr_i && (addr_i == ADDR_STATUS);
    clear_s    = {NUM_LINES{1'b0}};
    if (wr_i && (addr_i == ADDR_PENDING)) begin
      clear_s = dat_i[NUM_LINES-1:0];
    end else begin
      clear_s = {NUM_LINES{1'b0}};
    end
    if (ack_s) begin
      clear_s = clear_s | ({{(NUM_LINES-1){1'b0}}, 1'b1} << idx_q);
    end else begin
      clear_s = clear_s;
    end
    pending_d  = (pending_q & ~clear_s) | edge_s;
    eligible_s = pending_q & mask_q;
    winner_s   = lowest_index(eligible_s);
  end

  // Register read mux.
  always_comb begin
    dat_o = 8'h00;
    case (addr_i)
      ADDR_MASK:    dat_o = mask_q;
      ADDR_PENDING: dat_o = pending_q;
      ADDR_VBASE:   dat_o = vbase_q;
      ADDR_STATUS:  dat_o = {in_service_q, 4'b0000, idx_q};
      default:      dat_o = 8'h00;
    endcase
  end

  // Request history, pending latch and CPU-writable configuration.
  always_ff @(posedge fast_clock_i or posedge reset_i) begin
    if (reset_i) begin
      irq_prev_q   <= {NUM_LINES{1'b0}};
      hist_valid_q <= 1'b0;
      pending_q    <= {NUM_LINES{1'b0}};
      mask_q       <= {NUM_LINES{1'b0}};
      vbase_q      <= 8'h00;
    end else begin
      irq_prev_q   <= irq_i;
      hist_valid_q <= 1'b1;
      pending_q    <= pending_d;
      if (wr_i && (addr_i == ADDR_MASK)) begin
        mask_q <= dat_i[NUM_LINES-1:0];
      end
      if (wr_i && (addr_i == ADDR_VBASE)) begin
        vbase_q <= dat_i;
      end
    end
  end

  // Handshake FSM; n_int_o, vec_o, idx and in_service are all registered here.
  always_ff @(posedge fast_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      in_service_q <= 1'b0;
      vec_q        <= 8'h00;
      n_int_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eligible_s != {NUM_LINES{1'b0}}) begin
            idx_q   <= winner_s;
            state_q <= ST_REQ;
            n_int_q <= 1'b0;
          end else begin
            n_int_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            vec_q        <= {vbase_q[7:4], idx_q, 1'b0};
            in_service_q <= 1'b1;
            state_q      <= ST_SERV;
            n_int_q      <= 1'b1;
          end else if (eligible_s == {NUM_LINES{1'b0}}) begin
            state_q <= ST_IDLE;
            n_int_q <= 1'b1;
          end else begin
            idx_q   <= winner_s;
            n_int_q <= 1'b0;
          end
        end
        ST_SERV: begin
          n_int_q <= 1'b1;
          if (eoi_s) begin
            in_service_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          in_service_q <= 1'b0;
          n_int_q      <= 1'b1;
        end
      endcase
    end
  end

  assign n_int_o = n_int_q;
  assign vec_o   = vec_q;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed bench for int_priority_ctrl with hand-computed expectations.
module tb_int_priority_ctrl;

  logic       fast_clock_i = 1'b0;
  logic       reset_i      = 1'b1;
  logic [7:0] irq_i        = 8'h00;
  logic [1:0] addr_i       = 2'd0;
  logic       wr_i         = 1'b0;
  logic [7:0] dat_i        = 8'h00;
  logic [7:0] dat_o;
  logic       iack_i       = 1'b0;
  logic       n_int_o;
  logic [7:0] vec_o;

  int vectors   = 0;
  int miscompares = 0;

  int_priority_ctrl #(.NUM_LINES(8)) dut (
    .fast_clock_i(fast_clock_i),
    .reset_i     (reset_i),
    .irq_i       (irq_i),
    .addr_i      (addr_i),
    .wr_i        (wr_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .iack_i      (iack_i),
    .n_int_o     (n_int_o),
    .vec_o       (vec_o)
  );

  always #5 fast_clock_i = ~fast_clock_i;

  task automatic tick();
    @(posedge fast_clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr_i = a;
    #1;
    chk(tag, dat_o, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr_i = a;
    dat_i  = d;
    wr_i   = 1'b1;
    tick();
    wr_i   = 1'b0;
    dat_i  = 8'h00;
  endtask

  task automatic ack();
    iack_i = 1'b1;
    tick();
    iack_i = 1'b0;
  endtask

  initial begin
    // Reset with line 6 held high: must not register as an edge afterwards.
    irq_i = 8'h40;
    tick();
    tick();
    chk("rst_nint", {7'd0, n_int_o}, 8'h01);
    chk("rst_vec", vec_o, 8'h00);
    rd("rst_mask", 2'd0, 8'h00);
    rd("rst_vbase", 2'd2, 8'h00);
    rd("rst_status", 2'd3, 8'h00);
    reset_i = 1'b0;
    tick();
    tick();
    rd("held_irq_no_edge", 2'd1, 8'h00);
    irq_i = 8'h00;
    tick();

    // Basic request/ack on line 3.
    wr(2'd0, 8'hFF);
    wr(2'd2, 8'h40);
    irq_i = 8'h08;
    tick();
    irq_i = 8'h00;
    rd("l3_pending", 2'd1, 8'h08);
    chk("l3_nint_k1", {7'd0, n_int_o}, 8'h01);
    tick();
    chk("l3_nint_k2", {7'd0, n_int_o}, 8'h00);
    rd("l3_status_req", 2'd3, 8'h03);
    ack();
    chk("l3_vec", vec_o, 8'h46);
    chk("l3_nint_ack", {7'd0, n_int_o}, 8'h01);
    rd("l3_pending_ack", 2'd1, 8'h00);
    rd("l3_status_serv", 2'd3, 8'h83);
    ack();
    chk("serv_iack_vec", vec_o, 8'h46);
    rd("serv_iack_status", 2'd3, 8'h83);
    wr(2'd3, 8'h5A);
    rd("l3_eoi_status", 2'd3, 8'h03);
    wr(2'd3, 8'h00);
    rd("idle_eoi_status", 2'd3, 8'h03);

    // Line 5 requested, line 1 arrives before ack and takes over.
    irq_i = 8'h20;
    tick();
    irq_i = 8'h00;
    tick();
    chk("l5_nint", {7'd0, n_int_o}, 8'h00);
    rd("l5_status", 2'd3, 8'h05);
    irq_i = 8'h02;
    tick();
    irq_i = 8'h00;
    tick();
    rd("l1_preempt_status", 2'd3, 8'h01);
    chk("l1_nint", {7'd0, n_int_o}, 8'h00);
    ack();
    chk("l1_vec", vec_o, 8'h42);
    rd("l1_pending", 2'd1, 8'h20);
    rd("l1_status", 2'd3, 8'h81);
    wr(2'd3, 8'h00);
    chk("eoi_nint_c1", {7'd0, n_int_o}, 8'h01);
    tick();
    chk("eoi_nint_c2", {7'd0, n_int_o}, 8'h00);
    ack();
    chk("l5_vec", vec_o, 8'h4A);
    rd("l5_status_serv", 2'd3, 8'h85);
    rd("l5_pending", 2'd1, 8'h00);
    wr(2'd3, 8'h00);

    // Masked line stays pending without interrupting until enabled.
    wr(2'd0, 8'h00);
    irq_i = 8'h04;
    tick();
    irq_i = 8'h00;
    rd("l2_masked_pending", 2'd1, 8'h04);
    tick();
    tick();
    chk("l2_masked_nint", {7'd0, n_int_o}, 8'h01);
    wr(2'd0, 8'h04);
    chk("l2_unmask_c1", {7'd0, n_int_o}, 8'h01);
    tick();
    chk("l2_unmask_c2", {7'd0, n_int_o}, 8'h00);
    rd("l2_status", 2'd3, 8'h02);
    wr(2'd1, 8'h04);
    tick();
    chk("l2_cleared_nint", {7'd0, n_int_o}, 8'h01);

    // Masking line 4 while in REQ drops the request but keeps it pending.
    wr(2'd0, 8'h10);
    irq_i = 8'h10;
    tick();
    irq_i = 8'h00;
    tick();
    chk("l4_req_nint", {7'd0, n_int_o}, 8'h00);
    wr(2'd0, 8'h00);
    tick();
    chk("l4_masked_nint", {7'd0, n_int_o}, 8'h01);
    rd("l4_pending", 2'd1, 8'h10);
    ack();
    chk("idle_iack_vec", vec_o, 8'h4A);
    rd("idle_iack_pending", 2'd1, 8'h10);
    chk("idle_iack_nint", {7'd0, n_int_o}, 8'h01);

    // Edge on line 0 in the same cycle as a W1C of bit 0: set wins.
    irq_i = 8'h01;
    wr(2'd1, 8'h01);
    irq_i = 8'h00;
    rd("set_wins_pending", 2'd1, 8'h11);
    wr(2'd1, 8'h10);
    rd("w1c_pending", 2'd1, 8'h01);

    // Reach SERV on line 0 then assert reset asynchronously.
    wr(2'd0, 8'h01);
    tick();
    ack();
    chk("l0_vec", vec_o, 8'h40);
    rd("l0_status", 2'd3, 8'h80);
    reset_i = 1'b1;
    #1;
    chk("async_rst_vec", vec_o, 8'h00);
    chk("async_rst_nint", {7'd0, n_int_o}, 8'h01);
    rd("async_rst_status", 2'd3, 8'h00);
    rd("async_rst_mask", 2'd0, 8'h00);
    rd("async_rst_vbase", 2'd2, 8'h00);
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    chk("post_rst_nint", {7'd0, n_int_o}, 8'h01);
    rd("post_rst_pending", 2'd1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
